ram8_16: RTL and testbench



---
 rtl/ram8_16_pkg.sv | 21 ++
 rtl/ram8_16_register16.sv | 24 ++
 rtl/ram8_16.sv | 95 +++++++++
 tb/tb_ram8_16.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ram8_16_pkg.sv
// Shared constants and types for the ram8_16 register file.
package ram8_16_pkg;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  localparam logic [WIDTH-1:0] WORD_ZERO = '0;

  // Sweep controller states
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Address of the last word visited by the clear sweep
  function automatic logic [ADDR_W-1:0] last_addr();
    return ADDR_W'(DEPTH - 1);
  endfunction

endpackage

// File: rtl/ram8_16_register16.sv
// One storage word: register with load enable, async active-high reset to zero.
module register16
  import ram8_16_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Capture d_i whenever the word is selected for loading
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q_q <= '0;
    else if (ld_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

// File: rtl/ram8_16.sv
// ram8_16: 8 x 16-bit register file with one registered read port, one write
// port and a sequenced clear sweep (busy while sweeping).
// Optional macro RAM8_16_BYPASS_EN: same-address read+write on one edge
// returns the incoming write data instead of the stored word.
module ram8_16
  import ram8_16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clr,
  output logic              busy
);

  // Word storage, one register16 per entry
  logic [DEPTH-1:0][WIDTH-1:0] word_q;
  logic [DEPTH-1:0]            word_ld;
  logic [WIDTH-1:0]            word_d;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    register16 #(.W(WIDTH)) u_word (
      .clk  (clk),
      .rst  (rst),
      .ld_i (word_ld[i]),
      .d_i  (word_d),
      .q_o  (word_q[i])
    );
  end

  // Next state: port access in IDLE, one word cleared per edge in CLEAR
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_ld    = '0;
    word_d     = wr_data;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    case (state_q)
      IDLE: begin
        // A write on the clr edge still lands; the sweep wipes it afterwards.
        if (wr_en) word_ld[wr_addr] = 1'b1;
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_data_d  = word_q[rd_addr];
`ifdef RAM8_16_BYPASS_EN
          if (wr_en && (wr_addr == rd_addr)) rd_data_d = wr_data;
`endif
        end
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        word_ld[cnt_q] = 1'b1;
        word_d         = WORD_ZERO;
        cnt_d          = cnt_q + 1'b1;
        // Leaving on the last word keeps the 3-bit wrap from clearing word 0 again
        if (cnt_q == last_addr()) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller and read-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_data_q  <= WORD_ZERO;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram8_16.sv
// Directed table-driven bench for ram8_16.
module tb_ram8_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en, clr;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid, busy;

  int checks = 0;
  int errors = 0;

`ifdef RAM8_16_BYPASS_EN
  localparam logic [15:0] SAME_RD = 16'h1234;
`else
  localparam logic [15:0] SAME_RD = 16'hFFFF;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [2:0]  ra;
    logic        cl;
    logic        ev;
    logic [15:0] ed;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  ram8_16 dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .clr      (clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic we, logic [2:0] wa, logic [15:0] wd,
                              logic re, logic [2:0] ra, logic cl,
                              logic ev, logic [15:0] ed, logic eb);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.cl = cl;
    v.ev = ev; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, check outputs just after the rising edge
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    rd_en = v.re; rd_addr = v.ra; clr = v.cl;
    @(posedge clk);
    #1;
    chk({tag, " rd_valid"}, {15'd0, rd_valid}, {15'd0, v.ev});
    chk({tag, " rd_data"},  rd_data, v.ed);
    chk({tag, " busy"},     {15'd0, busy}, {15'd0, v.eb});
  endtask

  initial begin
    // reads after reset
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 1, 3'(i), 0, 1, 16'h0000, 0));
    // basic write/read
    tbl.push_back(mk(1, 3, 16'hA5A5, 0, 0, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0,        1, 3, 0, 1, 16'hA5A5, 0));
    tbl.push_back(mk(0, 0, 0,        1, 2, 0, 1, 16'h0000, 0));
    // same-address read/write
    tbl.push_back(mk(1, 5, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(1, 5, 16'h1234, 1, 5, 0, 1, SAME_RD,  0));
    tbl.push_back(mk(0, 0, 0,        1, 5, 0, 1, 16'h1234, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0, 0, 16'h1234, 0));
    // different-address read/write on one edge
    tbl.push_back(mk(1, 0, 16'h0F0F, 1, 3, 0, 1, 16'hA5A5, 0));
    // fill with BEEF, then sweep with ignored accesses during busy
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1, 3'(i), 16'hBEEF, 0, 0, 0, 0, 16'hA5A5, 0));
    tbl.push_back(mk(0, 0, 0, 1, 6, 0, 1, 16'hBEEF, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 16'hBEEF, 1));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(k == 2 || k == 8, (k == 8) ? 3'd1 : 3'd0, (k == 8) ? 16'h2222 : 16'h1111,
                       k == 1 || k == 8, (k == 8) ? 3'd1 : 3'd6, k == 3,
                       0, 16'hBEEF, k < 8));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, 1, 3'(i), 0, 1, 16'h0000, 0));
    // clr + write on one edge; repeated clr during busy must not extend it
    tbl.push_back(mk(1, 7, 16'h00FF, 0, 0, 1, 0, 16'h0000, 1));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, k == 4 || k == 7 || k == 8, 0, 16'h0000, k < 8));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 0, 1, 16'h0000, 0));
    // clr + read on one edge returns pre-sweep data
    tbl.push_back(mk(1, 2, 16'h4321, 0, 0, 0, 0, 16'h0000, 0));
    tbl.push_back(mk(0, 0, 0,        1, 2, 1, 1, 16'h4321, 1));
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 16'h4321, k < 8));
    tbl.push_back(mk(0, 0, 0, 1, 2, 0, 1, 16'h0000, 0));

    wr_en = 0; wr_addr = 0; wr_data = 0; rd_en = 0; rd_addr = 0; clr = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rd_data",  rd_data, 16'h0000);
    chk("reset rd_valid", {15'd0, rd_valid}, 16'h0000);
    chk("reset busy",     {15'd0, busy}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a sweep
    for (int i = 4; i < 8; i++) step(mk(1, 3'(i), 16'hBEEF, 0, 0, 0, 0, 16'h0000, 0), "pre");
    step(mk(0, 0, 0, 1, 4, 0, 1, 16'hBEEF, 0), "pre rd4");
    step(mk(0, 0, 0, 0, 0, 1, 0, 16'hBEEF, 1), "mid clr");
    for (int k = 1; k <= 4; k++) step(mk(0, 0, 0, 0, 0, 0, 0, 16'hBEEF, 1), "mid sweep");
    #1 rst = 1'b1;
    #1;
    chk("async rst busy",     {15'd0, busy}, 16'h0000);
    chk("async rst rd_data",  rd_data, 16'h0000);
    chk("async rst rd_valid", {15'd0, rd_valid}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    step(mk(1, 4, 16'h5A5A, 0, 0, 0, 0, 16'h0000, 0), "post wr4");
    step(mk(0, 0, 0, 1, 4, 0, 1, 16'h5A5A, 0), "post rd4");
    for (int i = 5; i < 8; i++) step(mk(0, 0, 0, 1, 3'(i), 0, 1, 16'h0000, 0), $sformatf("post rd%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
